// File: rtl/riscv_core_stalling.sv
// ---------------------------------------------------------------------------
// riscv_core_stalling
//
// Multi-cycle RV32I core. Instruction fetch and data access use separate
// request/acknowledge buses, so memories may stall for any number of cycles.
// The decoder, ALU, register file and load/store lane logic are all in this
// file.
// Each instruction walks FETCH -> EXEC (-> MEM for loads/stores) and commits
// in a single cycle. pc, the register file and instret change only on that
// commit edge, so a stalled access never disturbs architectural state.
// A request that waits BUS_TIMEOUT cycles without an ack moves the core to a
// terminal FAULT state. With HALT_ON_SYSTEM=1, a SYSTEM opcode moves it to a
// terminal HALT state.
//
// Ports
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   imem_req/addr          fetch request; address is the current pc
//   imem_ack/rdata         fetch complete, instruction word valid
//   dmem_req/we/addr       data request, 1 = store, word-aligned address
//   dmem_be/wdata          byte enables and lane-shifted store data
//   dmem_ack/rdata         access complete; raw load word valid for loads
//   pc                     current program counter
//   instret                retired-instruction count, wraps silently
//   halted                 sticky: core stopped (SYSTEM opcode or fault)
//   bus_fault              sticky: a bus request timed out
// ---------------------------------------------------------------------------
module riscv_core_stalling #(
  parameter int BUS_TIMEOUT    = 16,
  parameter int TIMEOUT_W      = 8,
  parameter int INSTRET_W      = 32,
  parameter bit HALT_ON_SYSTEM = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_be,
  output logic [31:0]          dmem_wdata,
  input  logic                 dmem_ack,
  input  logic [31:0]          dmem_rdata,
  output logic [31:0]          pc,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted,
  output logic                 bus_fault
);

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam bit                   TIMEOUT_EN = (BUS_TIMEOUT != 0);
  // The counter holds the number of wait cycles already seen. The limit is
  // reached when one more wait cycle would make it BUS_TIMEOUT.
  localparam logic [TIMEOUT_W-1:0] LIMIT_M1   = TIMEOUT_W'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_HALT, S_FAULT} state_t;

  state_t               state, state_nxt;
  logic [31:0]          ir;
  logic [31:0]          regs [32];
  logic [TIMEOUT_W-1:0] wait_cnt;

  logic        commit, wait_clr, wait_inc, timeout_hit;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_res, pc_plus4, next_pc, wb_data;
  logic [31:0] mem_addr, ld_shift, load_data;
  logic [1:0]  byte_off;
  logic        wb_en, taken, is_mem, is_store, is_system;

  // ---------------------------------------------------------------- decode
  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign f3        = ir[14:12];
  assign rs1       = ir[19:15];
  assign rs2       = ir[24:20];
  assign is_store  = (opcode == OP_STORE);
  assign is_mem    = (opcode == OP_LOAD) || is_store;
  assign is_system = (opcode == OP_SYSTEM);

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;

  // ------------------------------------------------------------------- ALU
  assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;

  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_res = 32'd0;
    case (f3)
      // ir[30] selects SUB only for register-register ops; in ADDI it is an
      // immediate bit.
      3'b000: alu_res = (opcode == OP_REG && ir[30]) ? rs1_val - alu_b
                                                     : rs1_val + alu_b;
      3'b001: alu_res = rs1_val << alu_b[4:0];
      3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_res = {31'd0, rs1_val < alu_b};
      3'b100: alu_res = rs1_val ^ alu_b;
      3'b101: alu_res = ir[30] ? $signed(rs1_val) >>> alu_b[4:0]
                               : rs1_val >> alu_b[4:0];
      3'b110: alu_res = rs1_val | alu_b;
      default: alu_res = rs1_val & alu_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = (rs1_val == rs2_val);
      3'b001: taken = (rs1_val != rs2_val);
      3'b100: taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: taken = (rs1_val <  rs2_val);
      3'b111: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // ------------------------------------------------------- load/store lanes
  assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
  assign byte_off = mem_addr[1:0];
  assign ld_shift = dmem_rdata >> {byte_off, 3'b000};

  // Misaligned addresses are not trapped; enables follow the low address bits.
  always_comb begin
    dmem_be = 4'b1111;
    case (f3[1:0])
      2'b00:   dmem_be = 4'b0001 << byte_off;
      2'b01:   dmem_be = byte_off[1] ? 4'b1100 : 4'b0011;
      default: dmem_be = 4'b1111;
    endcase
  end

  always_comb begin
    load_data = ld_shift;
    case (f3)
      3'b000:  load_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  load_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  load_data = {24'd0, ld_shift[7:0]};
      3'b101:  load_data = {16'd0, ld_shift[15:0]};
      default: load_data = ld_shift;
    endcase
  end

  // ir and the register file do not change while MEM waits, so all of these
  // outputs stay stable until the ack.
  assign dmem_addr  = {mem_addr[31:2], 2'b00};
  assign dmem_wdata = rs2_val << {byte_off, 3'b000};
  assign dmem_we    = dmem_req & is_store;
  assign imem_addr  = pc;

  // ------------------------------------------------- writeback and next pc
  // Opcodes not listed here (FENCE, SYSTEM when not halting, unknown) retire
  // as NOPs.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = alu_res;
    next_pc = pc_plus4;
    case (opcode)
      OP_LUI:    begin wb_en = 1'b1; wb_data = imm_u;       end
      OP_AUIPC:  begin wb_en = 1'b1; wb_data = pc + imm_u;  end
      OP_JAL:    begin wb_en = 1'b1; wb_data = pc_plus4; next_pc = pc + imm_j; end
      OP_JALR:   begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        next_pc = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (taken) next_pc = pc + imm_b;
      OP_LOAD:   begin wb_en = 1'b1; wb_data = load_data;   end
      OP_IMM,
      OP_REG:    wb_en = 1'b1;
      default:   ;
    endcase
  end

  // --------------------------------------------------------------- control
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == LIMIT_M1);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    wait_clr  = 1'b0;
    wait_inc  = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    case (state)
      S_FETCH: begin
        // The state resets to FETCH, so gate with reset_n to keep the
        // request low for the whole reset.
        imem_req = reset_n;
        if (imem_ack)         state_nxt = S_EXEC;
        else if (timeout_hit) state_nxt = S_FAULT;
        else                  wait_inc  = 1'b1;
      end
      S_EXEC: begin
        if (is_mem) begin
          state_nxt = S_MEM;
          wait_clr  = 1'b1;
        end else if (is_system && HALT_ON_SYSTEM) begin
          state_nxt = S_HALT;
        end else begin
          commit    = 1'b1;
          state_nxt = S_FETCH;
          wait_clr  = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        // An ack in the cycle the limit is reached takes priority.
        if (dmem_ack) begin
          commit    = 1'b1;
          state_nxt = S_FETCH;
          wait_clr  = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = S_FAULT;
        end else begin
          wait_inc  = 1'b1;
        end
      end
      default: ;  // HALT and FAULT are terminal; acks are ignored
    endcase
  end

  assign halted    = (state == S_HALT) || (state == S_FAULT);
  assign bus_fault = (state == S_FAULT);

  // NOTE: sequential state is written with non-blocking assignments, so every
  // register samples values from before the edge regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      ir       <= 32'd0;
      pc       <= 32'd0;
      instret  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (commit) begin
        pc      <= next_pc;
        instret <= instret + 1'b1;
      end
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // NOTE: the register file is a storage array and has no reset. Software
  // must write a register before it reads it. x0 is never written and always
  // reads as zero.
  always_ff @(posedge clock) begin
    if (commit && wb_en && rd != 5'd0) regs[rd] <= wb_data;
  end

endmodule
